// File: rtl/ifmap_mem_ctrl.sv
// IFMAP spike memory: stores NUM_TS timesteps of a 1-bit ifmap, loaded beat by beat,
// and serves rows to NUM_PE PEs as NoC packets {dest, opcode, data}.
module ifmap_mem_ctrl #(
    parameter int unsigned IFMAP_SIZE = 25,
    parameter int unsigned NUM_TS     = 2,
    parameter int unsigned NUM_PE     = 5,
    parameter int unsigned PE_BASE    = 5,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned PKT_W      = ADDR_W + OP_W + IFMAP_SIZE,
    parameter int unsigned PIX_W      = $clog2(IFMAP_SIZE * IFMAP_SIZE),
    parameter int unsigned TS_W       = (NUM_TS > 1) ? $clog2(NUM_TS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [TS_W-1:0]  ld_ts,
    input  logic [PIX_W-1:0] ld_addr,
    input  logic             ld_data,
    output logic             loaded,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_pkt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_pkt,
    output logic [TS_W-1:0]  cur_ts,
    output logic             err_ts
);

    localparam int unsigned NPIX  = IFMAP_SIZE * IFMAP_SIZE;
    localparam int unsigned TOTAL = NUM_TS * NPIX;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned PTR_W = $clog2(IFMAP_SIZE + NUM_PE + 1);
    localparam int unsigned PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned ROW_W = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;

    localparam logic [OP_W-1:0] OpWeightsDone = OP_W'(0);
    localparam logic [OP_W-1:0] OpPpeInput    = OP_W'(1);
    localparam logic [OP_W-1:0] OpRowsExh     = OP_W'(2);
    localparam logic [OP_W-1:0] OpTsDone      = OP_W'(15);

    typedef enum logic [1:0] {StIdle, StLoad, StBcast, StReply} state_e;

    state_e               r_state, w_state_nxt;
    logic                 r_loaded;
    logic [CNT_W-1:0]     r_count;
    logic [TS_W-1:0]      r_cur_ts;
    logic                 r_err_ts;
    logic [PTR_W-1:0]     r_ptr [NUM_PE];
    logic [PE_W-1:0]      r_bidx;
    logic                 r_out_valid;
    logic [PKT_W-1:0]     r_out_pkt;
    logic [IFMAP_SIZE-1:0] r_mem [NUM_TS][IFMAP_SIZE];

    logic            w_ld_hs, w_in_hs, w_out_hs, w_is_req, w_ts_last, w_last_beat, w_bcast_last;
    logic [OP_W-1:0] w_op;
    logic [31:0]     w_op_u, w_pix;
    logic [PE_W-1:0] w_req_pe;
    logic [ROW_W-1:0] w_row, w_col;
    logic [TS_W-1:0] w_ts_inc;
    logic            w_unused;

    assign w_ld_hs      = ld_valid & ld_ready;
    assign w_in_hs      = in_valid & in_ready;
    assign w_out_hs     = r_out_valid & out_ready;
    assign w_op         = in_pkt[IFMAP_SIZE +: OP_W];
    assign w_op_u       = 32'(w_op);
    assign w_is_req     = (w_op_u >= PE_BASE) && (w_op_u < PE_BASE + NUM_PE);
    assign w_req_pe     = PE_W'(w_op_u - PE_BASE);
    assign w_ts_last    = (32'(r_cur_ts) == NUM_TS - 1);
    assign w_ts_inc     = r_cur_ts + TS_W'(1);
    assign w_last_beat  = (r_count == CNT_W'(TOTAL - 1));
    assign w_bcast_last = (32'(r_bidx) == NUM_PE - 1);
    assign w_pix        = 32'(ld_addr);
    assign w_row        = ROW_W'(w_pix / IFMAP_SIZE);
    assign w_col        = ROW_W'(w_pix % IFMAP_SIZE);
    // Dest and data of requests carry no information for this node.
    assign w_unused     = ^{in_pkt[PKT_W-1:IFMAP_SIZE+OP_W], in_pkt[IFMAP_SIZE-1:0]};

    assign ld_ready  = (r_state == StLoad);
    // load_start has priority, so a coincident request is refused.
    assign in_ready  = (r_state == StIdle) & r_loaded & ~load_start;
    assign loaded    = r_loaded;
    assign out_valid = r_out_valid;
    assign out_pkt   = r_out_pkt;
    assign cur_ts    = r_cur_ts;
    assign err_ts    = r_err_ts;

    function automatic logic [IFMAP_SIZE-1:0] row_of(input logic [TS_W-1:0] ts,
                                                     input logic [ROW_W-1:0] r);
        return r_mem[ts][r];
    endfunction

    function automatic logic [PKT_W-1:0] mk_pkt(input int unsigned dest,
                                                 input logic [OP_W-1:0] op,
                                                 input logic [IFMAP_SIZE-1:0] data);
        return {ADDR_W'(dest), op, data};
    endfunction

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (load_start) begin
                    w_state_nxt = StLoad;
                end else if (w_in_hs) begin
                    if (w_op == OpWeightsDone) begin
                        w_state_nxt = StBcast;
                    end else if (w_op == OpTsDone) begin
                        if (!w_ts_last) w_state_nxt = StBcast;
                    end else if (w_is_req) begin
                        w_state_nxt = StReply;
                    end
                end
            end
            StLoad:  if (w_ld_hs && w_last_beat) w_state_nxt = StIdle;
            StBcast: if (w_out_hs && w_bcast_last) w_state_nxt = StIdle;
            StReply: if (w_out_hs) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // State, load counter, row pointers and the registered reply packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_loaded    <= 1'b0;
            r_count     <= '0;
            r_cur_ts    <= '0;
            r_err_ts    <= 1'b0;
            r_bidx      <= '0;
            r_out_valid <= 1'b0;
            r_out_pkt   <= '0;
            for (int k = 0; k < NUM_PE; k++) r_ptr[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                StIdle: begin
                    if (load_start) begin
                        r_loaded <= 1'b0;
                        r_count  <= '0;
                    end else if (w_in_hs) begin
                        if (w_op == OpWeightsDone ||
                            (w_op == OpTsDone && !w_ts_last)) begin
                            for (int k = 0; k < NUM_PE; k++) r_ptr[k] <= PTR_W'(k);
                            r_bidx      <= '0;
                            r_out_valid <= 1'b1;
                            if (w_op == OpTsDone) begin
                                r_cur_ts  <= w_ts_inc;
                                r_out_pkt <= mk_pkt(PE_BASE, OpPpeInput, row_of(w_ts_inc, '0));
                            end else begin
                                r_out_pkt <= mk_pkt(PE_BASE, OpPpeInput, row_of(r_cur_ts, '0));
                            end
                        end else if (w_op == OpTsDone) begin
                            r_err_ts <= 1'b1;
                        end else if (w_is_req) begin
                            r_out_valid <= 1'b1;
                            if (32'(r_ptr[w_req_pe]) < IFMAP_SIZE) begin
                                r_out_pkt <= mk_pkt(PE_BASE + 32'(w_req_pe), OpPpeInput,
                                                    row_of(r_cur_ts, ROW_W'(r_ptr[w_req_pe])));
                                r_ptr[w_req_pe] <= r_ptr[w_req_pe] + PTR_W'(NUM_PE);
                            end else begin
                                r_out_pkt <= mk_pkt(PE_BASE + 32'(w_req_pe), OpRowsExh, '0);
                            end
                        end
                    end
                end
                StLoad: begin
                    if (w_ld_hs) begin
                        r_count <= r_count + CNT_W'(1);
                        if (w_last_beat) r_loaded <= 1'b1;
                    end
                end
                StBcast: begin
                    if (w_out_hs) begin
                        r_ptr[r_bidx] <= PTR_W'(32'(r_bidx) + NUM_PE);
                        if (w_bcast_last) begin
                            r_out_valid <= 1'b0;
                        end else begin
                            r_bidx    <= r_bidx + PE_W'(1);
                            r_out_pkt <= mk_pkt(PE_BASE + 32'(r_bidx) + 1, OpPpeInput,
                                                row_of(r_cur_ts, ROW_W'(32'(r_bidx) + 1)));
                        end
                    end
                end
                StReply: if (w_out_hs) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Spike storage write port; out-of-range beats are counted but dropped.
    always_ff @(posedge clk) begin
        if (w_ld_hs && (32'(ld_ts) < NUM_TS) && (w_pix < NPIX)) begin
            r_mem[ld_ts][w_row][w_col] <= ld_data;
        end
    end

endmodule
